// File: rtl/seven_seg_dec.sv
// Registered BCD-to-seven-segment decoder with blanking, lamp test and ripple-blank.
// Define SEVEN_SEG_HEX_EN to show codes 10..15 as hex digits instead of a dash.
module seven_seg_dec #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    input  logic blank,
    input  logic lamp_test,
    input  logic rbi,
    output logic led_a,
    output logic led_b,
    output logic led_c,
    output logic led_d,
    output logic led_e,
    output logic led_f,
    output logic led_g,
    output logic rbo,
    output logic invalid
);

    // Segment vectors are ordered {a,b,c,d,e,f,g}; the mask flips them for common anode.
    localparam logic [6:0] POL_MASK  = {7{ACTIVE_LOW}};
    localparam logic [6:0] SEG_ALL   = 7'b1111111;
    localparam logic [6:0] SEG_NONE  = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;

    logic [3:0] code;
    logic [6:0] digit_seg;
    logic       digit_invalid;

    logic [6:0] seg_d,     seg_q;
    logic       rbo_d,     rbo_q;
    logic       invalid_d, invalid_q;

    assign code = {A, B, C, D};

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch can be inferred.
        digit_seg     = SEG_DASH;
        digit_invalid = 1'b0;
        unique case (code)
            4'd0:  digit_seg = 7'b1111110;
            4'd1:  digit_seg = 7'b0110000;
            4'd2:  digit_seg = 7'b1101101;
            4'd3:  digit_seg = 7'b1111001;
            4'd4:  digit_seg = 7'b0110011;
            4'd5:  digit_seg = 7'b1011011;
            4'd6:  digit_seg = 7'b1011111;
            4'd7:  digit_seg = 7'b1110000;
            4'd8:  digit_seg = 7'b1111111;
            4'd9:  digit_seg = 7'b1111011;
`ifdef SEVEN_SEG_HEX_EN
            4'd10: digit_seg = 7'b1110111;
            4'd11: digit_seg = 7'b0011111;
            4'd12: digit_seg = 7'b1001110;
            4'd13: digit_seg = 7'b0111101;
            4'd14: digit_seg = 7'b1001111;
            4'd15: digit_seg = 7'b1000111;
`else
            4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15: begin
                digit_seg     = SEG_DASH;
                digit_invalid = 1'b1;
            end
`endif
            default: digit_seg = SEG_DASH;
        endcase
    end

    always_comb begin
        seg_d     = SEG_NONE;
        rbo_d     = 1'b0;
        invalid_d = 1'b0;
        if (lamp_test) begin
            seg_d = SEG_ALL;
        end else if (blank) begin
            seg_d = SEG_NONE;
        end else if (rbi && (code == 4'd0)) begin
            // Leading zero suppressed; tell the next lower digit it may blank its zero too.
            seg_d = SEG_NONE;
            rbo_d = 1'b1;
        end else begin
            seg_d     = digit_seg;
            invalid_d = digit_invalid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_q     <= POL_MASK;
            rbo_q     <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            seg_q     <= seg_d ^ POL_MASK;
            rbo_q     <= rbo_d;
            invalid_q <= invalid_d;
        end
    end

    assign {led_a, led_b, led_c, led_d, led_e, led_f, led_g} = seg_q;
    assign rbo     = rbo_q;
    assign invalid = invalid_q;

endmodule

// File: tb/tb_seven_seg_dec.sv
// Self-checking bench for seven_seg_dec: directed plan items plus randomized traffic
// compared against a table-driven model; checks both output polarities at once.
module tb_seven_seg_dec;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, A, B, C, D, blank, lamp_test, rbi;
    logic cc_a, cc_b, cc_c, cc_d, cc_e, cc_f, cc_g, cc_rbo, cc_invalid;
    logic ca_a, ca_b, ca_c, ca_d, ca_e, ca_f, ca_g, ca_rbo, ca_invalid;

    seven_seg_dec #(.ACTIVE_LOW(1'b0)) dut_cc (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .D(D),
        .blank(blank), .lamp_test(lamp_test), .rbi(rbi),
        .led_a(cc_a), .led_b(cc_b), .led_c(cc_c), .led_d(cc_d),
        .led_e(cc_e), .led_f(cc_f), .led_g(cc_g),
        .rbo(cc_rbo), .invalid(cc_invalid)
    );

    seven_seg_dec #(.ACTIVE_LOW(1'b1)) dut_ca (
        .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .D(D),
        .blank(blank), .lamp_test(lamp_test), .rbi(rbi),
        .led_a(ca_a), .led_b(ca_b), .led_c(ca_c), .led_d(ca_d),
        .led_e(ca_e), .led_f(ca_f), .led_g(ca_g),
        .rbo(ca_rbo), .invalid(ca_invalid)
    );

    int checks = 0;
    int errors = 0;

    logic [6:0] glyph [16];

    task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // Reference: {segments a..g (lit=1), rbo, invalid} for the inputs seen at an edge.
    function automatic logic [8:0] model(input bit rst, input int code, input bit bl,
                                         input bit lt, input bit rb);
        bit is_hex_code;
        is_hex_code = (code >= 10);
        if (rst)               return 9'b0;
        if (lt)                return {7'b1111111, 2'b00};
        if (bl)                return {7'b0000000, 2'b00};
        if (rb && code == 0)   return {7'b0000000, 2'b10};
`ifdef SEVEN_SEG_HEX_EN
        return {glyph[code], 2'b00};
`else
        return {glyph[code], 1'b0, is_hex_code};
`endif
    endfunction

    function automatic logic [8:0] as_anode(input logic [8:0] v);
        return {v[8:2] ^ 7'b1111111, v[1:0]};
    endfunction

    // Drive one set of inputs, let one edge pass, then compare both DUTs.
    task automatic apply(input string tag, input bit rst, input int code,
                         input bit bl, input bit lt, input bit rb);
        logic [8:0] exp;
        logic [3:0] c4;
        c4 = 4'(code);
        rst_n = ~rst; {A, B, C, D} = c4; blank = bl; lamp_test = lt; rbi = rb;
        exp = model(rst, code, bl, lt, rb);
        @(posedge clk);
        #1;
        check({tag, "/cc"}, {cc_a, cc_b, cc_c, cc_d, cc_e, cc_f, cc_g, cc_rbo, cc_invalid}, exp);
        check({tag, "/ca"}, {ca_a, ca_b, ca_c, ca_d, ca_e, ca_f, ca_g, ca_rbo, ca_invalid},
              as_anode(exp));
    endtask

    initial begin
        logic [8:0] held;
        glyph[0]  = 7'b1111110; glyph[1]  = 7'b0110000; glyph[2]  = 7'b1101101;
        glyph[3]  = 7'b1111001; glyph[4]  = 7'b0110011; glyph[5]  = 7'b1011011;
        glyph[6]  = 7'b1011111; glyph[7]  = 7'b1110000; glyph[8]  = 7'b1111111;
        glyph[9]  = 7'b1111011;
`ifdef SEVEN_SEG_HEX_EN
        glyph[10] = 7'b1110111; glyph[11] = 7'b0011111; glyph[12] = 7'b1001110;
        glyph[13] = 7'b0111101; glyph[14] = 7'b1001111; glyph[15] = 7'b1000111;
`else
        for (int i = 10; i < 16; i++) glyph[i] = 7'b0000001;
`endif
        rst_n = 1'b0; {A, B, C, D} = 4'd0; blank = 1'b0; lamp_test = 1'b0; rbi = 1'b0;

        apply("reset1", 1, 8, 0, 0, 0);
        apply("reset2", 1, 8, 0, 0, 0);
        apply("release", 0, 8, 0, 0, 0);

        for (int i = 0; i < 16; i++) apply($sformatf("code%0d", i), 0, i, 0, 0, 0);

        apply("lamp_code5", 0, 5, 0, 1, 0);
        apply("lamp_and_blank", 0, 5, 1, 1, 0);
        apply("blank_only", 0, 5, 1, 0, 0);
        apply("rbi_zero", 0, 0, 0, 0, 1);
        apply("rbi_three", 0, 3, 0, 0, 1);
        apply("ca_code1", 0, 1, 0, 0, 0);

        // Mid-cycle input changes must not reach the outputs before the next edge.
        held = {cc_a, cc_b, cc_c, cc_d, cc_e, cc_f, cc_g, cc_rbo, cc_invalid};
        {A, B, C, D} = 4'd8; lamp_test = 1'b1;
        #2;
        check("hold_between_edges", {cc_a, cc_b, cc_c, cc_d, cc_e, cc_f, cc_g, cc_rbo, cc_invalid},
              model(0, 1, 0, 0, 0));
        check("hold_vs_prev", {cc_a, cc_b, cc_c, cc_d, cc_e, cc_f, cc_g, cc_rbo, cc_invalid}, held);
        @(negedge clk);

        for (int n = 0; n < 400; n++) begin
            bit r_rst, r_bl, r_lt, r_rb;
            int r_code;
            r_rst  = ($urandom_range(0, 15) == 0);
            r_bl   = ($urandom_range(0, 7) == 0);
            r_lt   = ($urandom_range(0, 7) == 0);
            r_rb   = $urandom_range(0, 1) == 1;
            r_code = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 15));
            apply($sformatf("rand%0d", n), r_rst, r_code, r_bl, r_lt, r_rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
